lemming_world: RTL and testbench

- Environment model that sits at the other end of the lemming walker interface.
- Consumes the walker's walk_left/walk_right direction outputs and tracks the lemming's position in a bounded 1-D corridor.
- Generates the bump_left/bump_right inputs the walker reacts to, so the walker FSM runs closed-loop in simulation and in on-chip self-test.
- Also keeps a bump counter and flags illegal direction encodings.

---
 rtl/lemming_world.sv | 119 +++++++++++
 tb/tb_lemming_world.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lemming_world.sv
// Corridor environment for the lemming walker: tracks position, raises one-cycle
// wall bumps, counts them (saturating) and halts on an illegal direction encoding.
module lemming_world #(
    parameter int POS_W     = 5,
    parameter int LEFT_WALL = 0,
    parameter int RIGHT_WALL = 31,
    parameter int START_POS = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             step_en,
    input  logic             walk_left,
    input  logic             walk_right,
    input  logic             err_clr,
    output logic             bump_left,
    output logic             bump_right,
    output logic [POS_W-1:0] pos,
    output logic [7:0]       bump_cnt,
    output logic             err
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] BUMP_L = 2'd1;
    localparam logic [1:0] BUMP_R = 2'd2;
    localparam logic [1:0] HALT   = 2'd3;

    localparam logic [POS_W-1:0] LEFT_POS  = POS_W'(LEFT_WALL);
    localparam logic [POS_W-1:0] RIGHT_POS = POS_W'(RIGHT_WALL);
    localparam logic [POS_W-1:0] START_P   = POS_W'(START_POS);

    logic [1:0]       state_r;
    logic [1:0]       state_next_s;
    logic [POS_W-1:0] pos_r;
    logic [POS_W-1:0] pos_next_s;
    logic [7:0]       bump_cnt_r;
    logic [7:0]       bump_cnt_next_s;
    logic             cnt_inc_s;
    logic             bump_left_r;
    logic             bump_right_r;
    logic             err_r;

    // Next-state, movement and bump-count decision for one movement opportunity
    always_comb begin
        state_next_s = state_r;
        pos_next_s   = pos_r;
        cnt_inc_s    = 1'b0;
        case (state_r)
            RUN: begin
                if (step_en) begin
                    if (walk_left && !walk_right) begin
                        if (pos_r > LEFT_POS) begin
                            pos_next_s = pos_r - {{(POS_W-1){1'b0}}, 1'b1};
                        end else begin
                            state_next_s = BUMP_L;
                            cnt_inc_s    = 1'b1;
                        end
                    end else if (walk_right && !walk_left) begin
                        if (pos_r < RIGHT_POS) begin
                            pos_next_s = pos_r + {{(POS_W-1){1'b0}}, 1'b1};
                        end else begin
                            state_next_s = BUMP_R;
                            cnt_inc_s    = 1'b1;
                        end
                    end else begin
                        state_next_s = HALT;
                    end
                end else begin
                    state_next_s = RUN;
                end
            end
            BUMP_L, BUMP_R: begin
                state_next_s = RUN;
            end
            HALT: begin
                if (err_clr) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = HALT;
                end
            end
            default: begin
                state_next_s = HALT;
            end
        endcase

        if (cnt_inc_s && (bump_cnt_r != 8'hFF)) begin
            bump_cnt_next_s = bump_cnt_r + 8'd1;
        end else begin
            bump_cnt_next_s = bump_cnt_r;
        end
    end

    // State and output registers; flags are decoded from the next state so they
    // come straight out of flops and line up with state_r
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_r      <= RUN;
            pos_r        <= START_P;
            bump_cnt_r   <= 8'd0;
            bump_left_r  <= 1'b0;
            bump_right_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            pos_r        <= pos_next_s;
            bump_cnt_r   <= bump_cnt_next_s;
            bump_left_r  <= (state_next_s == BUMP_L);
            bump_right_r <= (state_next_s == BUMP_R);
            err_r        <= (state_next_s == HALT);
        end
    end

    assign bump_left  = bump_left_r;
    assign bump_right = bump_right_r;
    assign pos        = pos_r;
    assign bump_cnt   = bump_cnt_r;
    assign err        = err_r;

endmodule

// File: tb/tb_lemming_world.sv
// Directed scoreboard bench for lemming_world, including closed-loop runs with a
// behavioural walker and a degenerate single-position build for counter saturation.
module tb_lemming_world;

    logic       clk;
    logic       areset;
    logic       step_en;
    logic       man_left;
    logic       man_right;
    logic       err_clr;
    logic       use_walker;
    logic       walk_left;
    logic       walk_right;
    logic       bump_left;
    logic       bump_right;
    logic [4:0] pos;
    logic [7:0] bump_cnt;
    logic       err;

    logic       step_en2;
    logic       walk_left2;
    logic       walk_right2;
    logic       bump_left2;
    logic       bump_right2;
    logic [4:0] pos2;
    logic [7:0] bump_cnt2;
    logic       err2;

    logic       wk_right_r;
    logic       wk2_right_r;

    int errors;
    int checks;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    lemming_world dut (
        .clk(clk), .areset(areset), .step_en(step_en),
        .walk_left(walk_left), .walk_right(walk_right), .err_clr(err_clr),
        .bump_left(bump_left), .bump_right(bump_right), .pos(pos),
        .bump_cnt(bump_cnt), .err(err)
    );

    lemming_world #(.POS_W(5), .LEFT_WALL(3), .RIGHT_WALL(3), .START_POS(3)) dut2 (
        .clk(clk), .areset(areset), .step_en(step_en2),
        .walk_left(walk_left2), .walk_right(walk_right2), .err_clr(1'b0),
        .bump_left(bump_left2), .bump_right(bump_right2), .pos(pos2),
        .bump_cnt(bump_cnt2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural walkers: start walking left, turn around on a bump
    always @(posedge clk or posedge areset) begin
        if (areset) begin
            wk_right_r  <= 1'b0;
            wk2_right_r <= 1'b0;
        end else begin
            if (bump_left)        wk_right_r <= 1'b1;
            else if (bump_right)  wk_right_r <= 1'b0;
            if (bump_left2)       wk2_right_r <= 1'b1;
            else if (bump_right2) wk2_right_r <= 1'b0;
        end
    end

    assign walk_left   = use_walker ? ~wk_right_r : man_left;
    assign walk_right  = use_walker ?  wk_right_r : man_right;
    assign walk_left2  = ~wk2_right_r;
    assign walk_right2 =  wk2_right_r;

    task automatic push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        tag = tag_q.pop_front();
        exp = exp_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        areset = 1'b1;
        #2;
        areset = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0;
        areset = 1'b1; step_en = 1'b0; step_en2 = 1'b0;
        man_left = 1'b0; man_right = 1'b0; err_clr = 1'b0; use_walker = 1'b1;

        // Reset held for two cycles
        tick(); tick();
        push("rst_pos", 32'd8);  push("rst_bl", 32'd0); push("rst_br", 32'd0);
        push("rst_err", 32'd0);  push("rst_cnt", 32'd0); push("rst_pos2", 32'd3);
        pop_check(32'(pos)); pop_check(32'(bump_left)); pop_check(32'(bump_right));
        pop_check(32'(err)); pop_check(32'(bump_cnt)); pop_check(32'(pos2));

        // Closed loop with walker, step_en continuous
        areset = 1'b0;
        step_en = 1'b1;
        for (int e = 1; e <= 43; e++) begin
            push("loop_bl", (e == 9) ? 32'd1 : 32'd0);
            push("loop_br", (e == 42) ? 32'd1 : 32'd0);
            tick();
            pop_check(32'(bump_left));
            pop_check(32'(bump_right));
            if (e == 8)  begin push("loop_pos8", 32'd0);   pop_check(32'(pos)); end
            if (e == 10) begin push("loop_wr10", 32'd1);   pop_check(32'(walk_right)); end
            if (e == 11) begin push("loop_pos11", 32'd1);  pop_check(32'(pos)); end
            if (e == 41) begin push("loop_pos41", 32'd31); pop_check(32'(pos)); end
        end
        push("loop_cnt", 32'd2); pop_check(32'(bump_cnt));

        // step_en toggling while walking left, then a bump followed by step_en low
        use_walker = 1'b0; man_left = 1'b1; man_right = 1'b0;
        pulse_reset();
        step_en = 1'b1; tick(); step_en = 1'b0; tick();
        step_en = 1'b1; tick(); step_en = 1'b0; tick();
        push("tog_pos", 32'd6); pop_check(32'(pos));
        step_en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        push("tog_pos0", 32'd0); pop_check(32'(pos));
        tick();
        push("tog_bl", 32'd1); push("tog_cnt", 32'd1); push("tog_bpos", 32'd0);
        pop_check(32'(bump_left)); pop_check(32'(bump_cnt)); pop_check(32'(pos));
        step_en = 1'b0; tick();
        push("tog_bl_off", 32'd0); push("tog_pos_hold", 32'd0);
        pop_check(32'(bump_left)); pop_check(32'(pos));
        step_en = 1'b1; man_left = 1'b0; man_right = 1'b1; tick();
        push("tog_pos1", 32'd1); push("tog_bl_none", 32'd0);
        pop_check(32'(pos)); pop_check(32'(bump_left));

        // Illegal 11 encoding at pos 5, then err_clr
        pulse_reset();
        man_left = 1'b1; man_right = 1'b0;
        tick(); tick(); tick();
        push("ill_pos5", 32'd5); pop_check(32'(pos));
        man_right = 1'b1; tick();
        push("ill_err", 32'd1); push("ill_pos", 32'd5);
        pop_check(32'(err)); pop_check(32'(pos));
        man_right = 1'b0; tick(); tick();
        push("halt_err", 32'd1); push("halt_pos", 32'd5);
        pop_check(32'(err)); pop_check(32'(pos));
        err_clr = 1'b1; tick();
        push("clr_err", 32'd0); push("clr_pos", 32'd5);
        pop_check(32'(err)); pop_check(32'(pos));
        err_clr = 1'b0; tick();
        push("resume_pos", 32'd4); pop_check(32'(pos));

        // 00 encoding: ignored without step_en, halts with it
        man_left = 1'b0; man_right = 1'b0; step_en = 1'b0; tick();
        push("z_noerr", 32'd0); push("z_pos", 32'd4);
        pop_check(32'(err)); pop_check(32'(pos));
        step_en = 1'b1; tick();
        push("z_err", 32'd1); pop_check(32'(err));
        err_clr = 1'b1; tick();
        push("z_clr", 32'd0); pop_check(32'(err));

        // err_clr outside HALT has no effect
        man_left = 1'b1; tick();
        push("clr_run_pos", 32'd3); push("clr_run_err", 32'd0);
        pop_check(32'(pos)); pop_check(32'(err));
        err_clr = 1'b0;

        // Async reset during BUMP_L
        tick(); tick(); tick(); tick();
        push("pre_rst_bl", 32'd1); pop_check(32'(bump_left));
        #2 areset = 1'b1;
        #1;
        push("arst_bl", 32'd0); push("arst_pos", 32'd8); push("arst_cnt", 32'd0);
        push("arst_err", 32'd0);
        pop_check(32'(bump_left)); pop_check(32'(pos)); pop_check(32'(bump_cnt));
        pop_check(32'(err));
        step_en = 1'b0;
        tick();
        areset = 1'b0;

        // Degenerate single-position build: every step bumps, counter saturates
        step_en2 = 1'b1;
        for (int e = 1; e <= 620; e++) begin
            push("deg_pos", 32'd3);
            tick();
            pop_check(32'(pos2));
            if (e == 507) begin push("deg_cnt254", 32'd254); pop_check(32'(bump_cnt2)); end
            if (e == 509) begin push("deg_cnt255", 32'd255); pop_check(32'(bump_cnt2)); end
        end
        push("deg_cnt_hold", 32'd255); push("deg_err", 32'd0);
        pop_check(32'(bump_cnt2)); pop_check(32'(err2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
